gcd_dispatcher: RTL
===================

GCD_DISPATCHER -- requirements
Module: gcd_dispatcher

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits.
REQ-002 Parameter DEPTH, default 4, operand FIFO depth; power of two, at least 2.
REQ-003 Parameter TIMEOUT, default 1023, maximum WAIT cycles before a job is aborted.
REQ-004 Port clk  in  1  clock, rising-edge; reset  in  1  reset, asynchronous, active-high.
REQ-005 Port in_valid  in  1  operand pair offered.
REQ-006 Port in_ready  out  1  FIFO can accept a pair.
REQ-007 Ports in_a, in_b  in  WIDTH  unsigned operands.
REQ-008 Port core_start  out  1  one-cycle start pulse to the GCD core.
REQ-009 Ports core_a, core_b  out  WIDTH  operands presented to the core.
REQ-010 Port core_done  in  1  core result valid.
REQ-011 Port core_result  in  WIDTH  core GCD value.
REQ-012 Port out_valid  out  1  result available; out_ready  in  1  consumer accepts.
REQ-013 Ports out_result  out  WIDTH  GCD value; out_err  out  1  job aborted by timeout.
REQ-014 Port fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 A pair SHALL be written to the FIFO tail on every edge where in_valid and in_ready are both high.
REQ-016 in_ready SHALL equal (fifo_count < DEPTH), using registered count; when the FIFO is full, a push SHALL NOT be accepted even if a pop occurs in the same cycle.
REQ-017 The FSM SHALL use states IDLE, LAUNCH, WAIT, RESP.
REQ-018 In IDLE with FIFO non-empty, the FSM SHALL pop the head into core_a/core_b.
REQ-019 If either popped operand is zero, the FSM SHALL go to RESP with out_result = (a==0 ? b : a), out_err=0, and no core_start; otherwise it SHALL go to LAUNCH.
REQ-020 In LAUNCH, core_start SHALL be high for exactly that one cycle; the FSM then SHALL go to WAIT with the watchdog cleared.
REQ-021 core_a/core_b SHALL remain stable from LAUNCH until the FSM leaves WAIT.
REQ-022 In WAIT, core_done high SHALL capture core_result into out_result with out_err=0 and move to RESP.
REQ-023 The watchdog SHALL increment each WAIT cycle; on reaching TIMEOUT, the block SHALL set out_result=0, out_err=1, and move to RESP.
REQ-024 If core_done and the timeout coincide, core_done SHALL win.
REQ-025 core_done SHALL be ignored outside WAIT.
REQ-026 In RESP, out_valid SHALL be high, with out_result and out_err held stable until out_ready is high; on that handshake the FSM SHALL return to IDLE.
REQ-027 Latency: core_start SHALL assert on the second edge after acceptance into an empty FIFO with the FSM idle; a zero-bypass job's out_valid SHALL assert on the second edge after acceptance.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; push and pop in the same cycle SHALL leave fifo_count unchanged.

Reset
REQ-029 Reset SHALL force: state IDLE; FIFO pointers, fifo_count, and watchdog to 0; core_start, core_a, core_b, out_valid, out_result, and out_err to 0.
REQ-030 Reset mid-operation SHALL discard all queued and in-flight jobs; a core_done arriving after reset SHALL be ignored.

Structure
REQ-031 Package gcd_pkg SHALL hold the FSM state encoding and the default WIDTH, DEPTH, and TIMEOUT constants.
REQ-032 Storage SHALL be a sub-module gcd_op_fifo: a synchronous FIFO, 2*WIDTH wide, DEPTH deep, with count output.

Verification
REQ-033 Push (48,18), core model done after 10 cycles with 6 -> single core_start with core_a=48, core_b=18; out_result=6, out_err=0.
REQ-034 Push (0,35) then (0,0) -> no core_start; results 35 then 0, each two edges after acceptance.
REQ-035 Core never done, TIMEOUT=15, push 6 pairs back-to-back -> first pair in WAIT, fifo_count=4, in_ready=0, sixth pair held off.
REQ-036 Same stall -> after 15 WAIT cycles out_err=1, out_result=0; the next job launches after the RESP handshake.
REQ-037 out_ready low for 5 cycles in RESP -> out_valid, out_result, and out_err stable; no new core_start.
REQ-038 Reset asserted during WAIT, then core_done pulsed -> all outputs 0, fifo_count=0, out_valid stays 0.

Source files
------------

// File: rtl/gcd_pkg.sv
// gcd_pkg
// Shared definitions for the GCD dispatcher slice.
//   - gcdState_e : dispatcher FSM state encoding
//   - DEF_*      : default WIDTH / DEPTH / TIMEOUT values
package gcd_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } gcdState_e;

endpackage

// File: rtl/gcd_dispatcher_if.sv
// gcd_dispatcher_if
// Bundles the three handshakes of the dispatcher:
//   in_*   : operand pair producer -> dispatcher (valid/ready)
//   core_* : dispatcher <-> external GCD core (start pulse, done strobe)
//   out_*  : dispatcher -> result consumer (valid/ready), plus fifo_count
// modport slave  : the dispatcher side
// modport master : the environment (producer, core, consumer)
interface gcd_dispatcher_if import gcd_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_a;
    logic [WIDTH-1:0]         in_b;
    logic                     core_start;
    logic [WIDTH-1:0]         core_a;
    logic [WIDTH-1:0]         core_b;
    logic                     core_done;
    logic [WIDTH-1:0]         core_result;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_result;
    logic                     out_err;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport slave (
        input  in_valid, in_a, in_b, core_done, core_result, out_ready,
        output in_ready, core_start, core_a, core_b,
               out_valid, out_result, out_err, fifo_count
    );

    modport master (
        output in_valid, in_a, in_b, core_done, core_result, out_ready,
        input  in_ready, core_start, core_a, core_b,
               out_valid, out_result, out_err, fifo_count
    );
endinterface

// File: rtl/gcd_op_fifo.sv
// gcd_op_fifo
// Synchronous FIFO holding packed operand pairs.
//   clk, reset : clock, async active-high reset
//   push/wrData: write request (ignored when full)
//   pop/rdData : head is always visible on rdData; pop ignored when empty
//   ready      : registered count below DEPTH
//   count      : current occupancy
module gcd_op_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [DW-1:0]          wrData,
    input  logic                   pop,
    output logic [DW-1:0]          rdData,
    output logic                   ready,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;

    // ready comes from the registered count only, so a full FIFO refuses a
    // push even when the head is popped in the same cycle.
    assign ready  = (count < CW'(DEPTH));
    assign doPush = push && ready;
    assign doPop  = pop && (count != '0);
    assign rdData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wrData;
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/gcd_dispatcher.sv
// gcd_dispatcher
// Queues operand pairs and feeds them one at a time to an external GCD core.
// Pairs with a zero operand are answered locally without using the core.
// A watchdog aborts a job whose core never reports done.
//   clk, reset : clock, async active-high reset
//   bus        : gcd_dispatcher_if.slave (in_*, core_*, out_*, fifo_count)
module gcd_dispatcher import gcd_pkg::*; #(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    gcd_dispatcher_if.slave  bus
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    gcdState_e         state, stateNext;
    logic [WDW-1:0]    wdog, wdogNext;
    logic              coreStart, coreStartNext;
    logic [WIDTH-1:0]  coreA, coreANext;
    logic [WIDTH-1:0]  coreB, coreBNext;
    logic              outValid, outValidNext;
    logic [WIDTH-1:0]  outResult, outResultNext;
    logic              outErr, outErrNext;
    logic              pop;
    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0]  headA, headB;
    logic [$clog2(DEPTH):0] fifoCount;

    gcd_op_fifo #(.DW(2*WIDTH), .DEPTH(DEPTH)) uFifo (
        .clk    (clk),
        .reset  (reset),
        .push   (bus.in_valid),
        .wrData ({bus.in_a, bus.in_b}),
        .pop    (pop),
        .rdData (head),
        .ready  (bus.in_ready),
        .count  (fifoCount)
    );

    assign headA          = head[2*WIDTH-1:WIDTH];
    assign headB          = head[WIDTH-1:0];
    assign bus.fifo_count = fifoCount;
    assign bus.core_start = coreStart;
    assign bus.core_a     = coreA;
    assign bus.core_b     = coreB;
    assign bus.out_valid  = outValid;
    assign bus.out_result = outResult;
    assign bus.out_err    = outErr;

    always_comb begin
        stateNext     = state;
        wdogNext      = wdog;
        coreStartNext = 1'b0;
        coreANext     = coreA;
        coreBNext     = coreB;
        outValidNext  = outValid;
        outResultNext = outResult;
        outErrNext    = outErr;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (fifoCount != '0) begin
                    pop       = 1'b1;
                    coreANext = headA;
                    coreBNext = headB;
                    // gcd(x,0) = x, so a zero operand never needs the core.
                    if (headA == '0 || headB == '0) begin
                        stateNext     = RESP;
                        outValidNext  = 1'b1;
                        outResultNext = (headA == '0) ? headB : headA;
                        outErrNext    = 1'b0;
                    end else begin
                        stateNext     = LAUNCH;
                        coreStartNext = 1'b1;
                    end
                end
            end
            LAUNCH: begin
                stateNext = WAIT;
                wdogNext  = '0;
            end
            WAIT: begin
                wdogNext = wdog + 1'b1;
                // done is tested first so it wins over a coincident timeout
                if (bus.core_done) begin
                    stateNext     = RESP;
                    outValidNext  = 1'b1;
                    outResultNext = bus.core_result;
                    outErrNext    = 1'b0;
                end else if (wdogNext == WDW'(TIMEOUT)) begin
                    stateNext     = RESP;
                    outValidNext  = 1'b1;
                    outResultNext = '0;
                    outErrNext    = 1'b1;
                end
            end
            RESP: begin
                if (bus.out_ready) begin
                    stateNext    = IDLE;
                    outValidNext = 1'b0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wdog      <= '0;
            coreStart <= 1'b0;
            coreA     <= '0;
            coreB     <= '0;
            outValid  <= 1'b0;
            outResult <= '0;
            outErr    <= 1'b0;
        end else begin
            state     <= stateNext;
            wdog      <= wdogNext;
            coreStart <= coreStartNext;
            coreA     <= coreANext;
            coreB     <= coreBNext;
            outValid  <= outValidNext;
            outResult <= outResultNext;
            outErr    <= outErrNext;
        end
    end
endmodule
